adc_frame_buffer: RTL and testbench

Upstream capture stage for the phase-difference (cross-correlation) engine. It accepts strobed dual-channel ADC samples (voltage and current) in offset-binary format and converts them to signed two's complement. It packs the samples into frames of N simultaneous pairs using a ping-pong pair of banks. Complete frames stream to the downstream correlator over a valid/ready interface, with start-of-frame and end-of-frame markers.

---
 rtl/adc_frame_buffer.sv | 166 ++++++++++++++++
 tb/tb_adc_frame_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_buffer.sv
// Dual-channel ADC capture into ping-pong frame banks, streamed out over valid/ready.
// Offset-binary samples are stored as two's complement pairs; frames never mix banks.
module adc_frame_buffer #(
  parameter int N  = 1024,
  parameter int AW = 10,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_v,
  input  logic [DW-1:0] adc_i,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_sig1,
  output logic [DW-1:0] out_sig2,
  output logic          out_sof,
  output logic          out_eof,
  output logic          overrun,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM
  } rd_state_e;

  function automatic logic signed [DW-1:0] ob_to_tc(input logic [DW-1:0] raw);
    return {~raw[DW-1], raw[DW-2:0]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2*DW-1:0] mem_q [2*N];

  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]    full_q, full_d;
  logic          wr_blocked, wr_en, wr_last;

  rd_state_e     state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic          out_valid_q, out_valid_d;
  logic [2*DW-1:0] out_data_q;
  logic          rd_en, rd_xfer, rd_done;
  logic [AW-1:0] rd_addr;

  logic          overrun_q, overrun_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  // Write side: a FULL target bank blocks capture until the reader frees it
  assign wr_blocked = full_q[wr_bank_q];
  assign wr_en      = adc_valid && !wr_blocked;
  assign wr_last    = wr_en && (wr_idx_q == AW'(N-1));

  assign rd_xfer = out_valid_q && out_ready;
  assign rd_done = rd_xfer && (out_idx_q == AW'(N-1));

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    full_d    = full_q;
    if (wr_en) begin
      wr_idx_d = wr_idx_q + AW'(1);
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end
    end
    // Freed bank becomes writable from the next cycle only
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[{wr_bank_q, wr_idx_q}] <= {ob_to_tc(adc_v), ob_to_tc(adc_i)};
  end

  // Read side: the registered RAM output doubles as the output holding register,
  // advancing only on a transfer, so stalls keep data stable and streaming is 1/cycle
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    rd_en       = 1'b0;
    rd_addr     = out_idx_q + AW'(1);
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_en       = 1'b1;
        rd_addr     = '0;
        out_idx_d   = '0;
        out_valid_d = 1'b1;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        if (rd_done) begin
          out_valid_d = 1'b0;
          rd_bank_d   = ~rd_bank_q;
          state_d     = S_IDLE;
        end else if (rd_xfer) begin
          rd_en     = 1'b1;
          out_idx_d = out_idx_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (rd_en) begin
      out_data_q <= mem_q[{rd_bank_q, rd_addr}];
    end
  end

  assign overrun_d   = adc_valid && wr_blocked;
  assign drop_cnt_d  = overrun_d ? sat_inc16(drop_cnt_q) : drop_cnt_q;
  assign frame_cnt_d = frame_cnt_q + 16'(rd_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      full_q      <= '0;
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sig1  = out_data_q[2*DW-1:DW];
  assign out_sig2  = out_data_q[DW-1:0];
  assign out_sof   = out_valid_q && (out_idx_q == '0);
  assign out_eof   = out_valid_q && (out_idx_q == AW'(N-1));
  assign overrun   = overrun_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Bench for adc_frame_buffer: frame-queue reference model checked every cycle,
// plus directed literal expectations on captured transfers.
module tb_adc_frame_buffer;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          adc_valid;
  logic [DW-1:0] adc_v, adc_i;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_sig1, out_sig2;
  logic          out_sof, out_eof, overrun;
  logic [15:0]   drop_cnt, frame_cnt;

  adc_frame_buffer #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_v(adc_v), .adc_i(adc_i),
    .out_ready(out_ready), .out_valid(out_valid), .out_sig1(out_sig1), .out_sig2(out_sig2),
    .out_sof(out_sof), .out_eof(out_eof), .overrun(overrun),
    .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle", name, act, exp);
    end
  endtask

  // Reference model: pending frames as a flat queue of expected pairs
  int cyc = 0;
  bit m_live = 0;
  int exp1_q[$], exp2_q[$], cur1_q[$], cur2_q[$];
  int done_q[$];
  int m_pos, m_drop, m_fcnt, last_eof;
  bit m_ovr, m_valid;
  int got1[$], got2[$];
  int rise_cyc, eof_edge, ovr_seen;
  bit prev_valid = 0;

  always @(posedge clk) begin
    bit blocked, xfer;
    int avail;
    cyc++;
    if (out_valid && out_ready) begin
      got1.push_back(int'($signed(out_sig1)));
      got2.push_back(int'($signed(out_sig2)));
      if (out_eof) eof_edge = cyc;
    end
    if (rst) begin
      m_live = 1;
      exp1_q.delete(); exp2_q.delete(); cur1_q.delete(); cur2_q.delete(); done_q.delete();
      m_pos = 0; m_drop = 0; m_fcnt = 0; m_ovr = 0; m_valid = 0; last_eof = cyc;
    end else if (m_live) begin
      xfer    = m_valid && out_ready;
      blocked = (done_q.size() == 2);
      m_ovr   = 0;
      if (adc_valid) begin
        if (blocked) begin
          m_ovr = 1;
          if (m_drop < 65535) m_drop++;
        end else begin
          cur1_q.push_back(int'(adc_v) - 2048);
          cur2_q.push_back(int'(adc_i) - 2048);
          if (cur1_q.size() == N) begin
            for (int k = 0; k < N; k++) begin
              exp1_q.push_back(cur1_q[k]);
              exp2_q.push_back(cur2_q[k]);
            end
            done_q.push_back(cyc);
            cur1_q.delete(); cur2_q.delete();
          end
        end
      end
      if (xfer) begin
        void'(exp1_q.pop_front());
        void'(exp2_q.pop_front());
        m_pos++;
        if (m_pos == N) begin
          m_pos = 0;
          void'(done_q.pop_front());
          m_fcnt = (m_fcnt + 1) % 65536;
          last_eof = cyc;
        end
      end
      m_valid = 0;
      if (done_q.size() > 0) begin
        avail = (done_q[0] > last_eof) ? done_q[0] : last_eof;
        m_valid = (cyc >= avail + 2);
      end
    end
    #1;
    if (m_live) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("sig1", int'($signed(out_sig1)), exp1_q[0]);
        chk("sig2", int'($signed(out_sig2)), exp2_q[0]);
        chk("sof", int'(out_sof), int'(m_pos == 0));
        chk("eof", int'(out_eof), int'(m_pos == N-1));
      end else begin
        chk("sof_idle", int'(out_sof), 0);
        chk("eof_idle", int'(out_eof), 0);
      end
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("frame_cnt", int'(frame_cnt), m_fcnt);
      if (overrun) ovr_seen++;
      if (out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = out_valid;
    end
  end

  // Stimulus helpers: everything steps on the falling edge
  bit rand_ready = 0;
  int last_strobe_edge;

  task automatic tick();
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(1, 0) == 1);
  endtask

  task automatic strobe(input int v, input int i);
    tick();
    adc_valid = 1'b1;
    adc_v = v[DW-1:0];
    adc_i = i[DW-1:0];
    last_strobe_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      adc_valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target, input int limit);
    int n = 0;
    while (int'(frame_cnt) != target && n < limit) begin
      idle(1);
      n++;
    end
    if (int'(frame_cnt) != target) chk("frame_timeout", int'(frame_cnt), target);
  endtask

  task automatic reset_pulse();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    adc_valid = 1'b0;
  endtask

  int corner[3] = '{0, 2048, 4095};
  int n;

  initial begin
    rst = 1'b1; adc_valid = 1'b0; adc_v = '0; adc_i = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sig1", int'(out_sig1), 0);
    chk("rst_sig2", int'(out_sig2), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_frames", int'(frame_cnt), 0);
    rst = 1'b0;

    // Single frame, ramp data, ready held high
    out_ready = 1'b1;
    got1.delete(); got2.delete();
    for (int k = 0; k < N; k++) strobe(k % 4096, 4095 - k);
    idle(1);
    wait_frames(1, 1500);
    chk("t1_latency", rise_cyc, last_strobe_edge + 2);
    chk("t1_burst", eof_edge, rise_cyc + N);
    chk("t1_count", got1.size(), N);
    chk("t1_sig1_0", got1[0], -2048);
    chk("t1_sig2_0", got2[0], 2047);
    chk("t1_sig1_last", got1[N-1], -1025);
    chk("t1_sig2_last", got2[N-1], 1024);
    chk("t1_frames", int'(frame_cnt), 1);

    // Conversion corners at the head of a frame
    got1.delete(); got2.delete();
    for (int k = 0; k < N; k++) begin
      if (k < 3) strobe(corner[k], corner[k]);
      else strobe(k, k);
    end
    idle(1);
    wait_frames(2, 1500);
    chk("cv_v0", got1[0], -2048);
    chk("cv_v2048", got1[1], 0);
    chk("cv_v4095", got1[2], 2047);
    chk("cv_i0", got2[0], -2048);
    chk("cv_i2048", got2[1], 0);
    chk("cv_i4095", got2[2], 2047);

    // Random backpressure and random strobe gaps
    got1.delete(); got2.delete();
    rand_ready = 1;
    for (int k = 0; k < N; k++) begin
      strobe($urandom_range(4095, 0), $urandom_range(4095, 0));
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    idle(1);
    wait_frames(3, 6000);
    chk("bp_count", got1.size(), N);
    rand_ready = 0;

    // Overrun: two frames captured with the reader stalled, then five extras
    out_ready = 1'b0;
    ovr_seen = 0;
    for (int k = 0; k < 2*N + 5; k++) strobe($urandom_range(4095, 0), $urandom_range(4095, 0));
    idle(2);
    chk("ov_drop", int'(drop_cnt), 5);
    chk("ov_pulses", ovr_seen, 5);
    out_ready = 1'b1;
    wait_frames(4, 1500);
    for (int k = 0; k < N; k++) strobe(k, 4095 - k);
    idle(1);
    wait_frames(6, 3000);
    chk("ov_drop_final", int'(drop_cnt), 5);

    // Continuous ping-pong, strobe every other cycle
    for (int k = 0; k < 4*N; k++) begin
      strobe($urandom_range(4095, 0), $urandom_range(4095, 0));
      idle(1);
    end
    wait_frames(10, 3000);
    chk("pp_frames", int'(frame_cnt), 10);
    chk("pp_drop", int'(drop_cnt), 5);

    // Reset while streaming index 500
    for (int k = 0; k < N; k++) strobe(k, k);
    idle(1);
    n = 0;
    while (!(m_valid && m_pos == 500) && n < 2000) begin
      idle(1);
      n++;
    end
    chk("rs_reach500", m_pos, 500);
    reset_pulse();
    chk("rs_valid", int'(out_valid), 0);
    chk("rs_frames", int'(frame_cnt), 0);
    chk("rs_drop", int'(drop_cnt), 0);

    // Reset during write index 300, then one clean frame
    for (int k = 0; k < 300; k++) strobe(k, k);
    reset_pulse();
    chk("rw_valid", int'(out_valid), 0);
    got1.delete(); got2.delete();
    for (int k = 0; k < N; k++) strobe(k, 4095 - k);
    idle(1);
    wait_frames(1, 1500);
    chk("rw_frames", int'(frame_cnt), 1);
    chk("rw_count", got1.size(), N);
    chk("rw_first", got1[0], -2048);
    chk("rw_last2", got2[N-1], 1024);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
